// File: rtl/qm_mem_responder_if.sv
// qm_mem_responder_if: cache-side DRAM user-port bundle (command, write and read channels).
interface qm_mem_responder_if;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_addr;
  logic        cmd_full;
  logic        cmd_empty;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty;
  logic        rd_full;
  logic [6:0]  rd_count;
  logic        busy;

  // Cache side: issues commands, pushes write words, pops read words.
  modport master (
    output cmd_en, cmd_instr, cmd_bl, cmd_addr, wr_en, wr_mask, wr_data, rd_en,
    input  cmd_full, cmd_empty, wr_full, wr_empty, wr_count, wr_underrun,
    input  rd_data, rd_empty, rd_full, rd_count, busy
  );

  // Responder side: services the port from on-chip RAM.
  modport slave (
    input  cmd_en, cmd_instr, cmd_bl, cmd_addr, wr_en, wr_mask, wr_data, rd_en,
    output cmd_full, cmd_empty, wr_full, wr_empty, wr_count, wr_underrun,
    output rd_data, rd_empty, rd_full, rd_count, busy
  );
endinterface

// File: rtl/qm_mem_responder.sv
// qm_mem_responder: DRAM user-port responder backed by an on-chip word RAM.
// Command, write and read FIFOs feed a three-state engine that executes
// one burst at a time, strictly in command order.
module qm_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int CMD_DEPTH  = 4,
  parameter int DATA_DEPTH = 64
) (
  input logic               clk,
  input logic               reset,
  qm_mem_responder_if.slave bus
);
  localparam int CW = $clog2(CMD_DEPTH);
  localparam int DW = $clog2(DATA_DEPTH);
  localparam int CE = 3 + 6 + ADDR_WIDTH;
  localparam logic [CW:0] CMD_DEPTH_C  = (CW+1)'(CMD_DEPTH);
  localparam logic [DW:0] DATA_DEPTH_C = (DW+1)'(DATA_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  // Command FIFO: {instr, bl, word address}
  logic [CE-1:0]         cmd_mem_r [CMD_DEPTH];
  logic [CW-1:0]         cmd_wptr_r, cmd_rptr_r;
  logic [CW:0]           cmd_cnt_r;
  logic                  cmd_push_s, cmd_pop_s, cmd_empty_s, cmd_full_s;
  logic [2:0]            head_instr_s;
  logic [5:0]            head_bl_s;
  logic [ADDR_WIDTH-1:0] head_ptr_s;
  // Write FIFO: {mask, data}
  logic [35:0]           wr_mem_r [DATA_DEPTH];
  logic [DW-1:0]         wr_wptr_r, wr_rptr_r;
  logic [DW:0]           wr_cnt_r;
  logic                  wr_push_s, wr_pop_s, wr_empty_s, wr_full_s;
  logic [3:0]            wr_head_mask_s;
  logic [31:0]           wr_head_data_s;
  // Read FIFO
  logic [31:0]           rd_mem_r [DATA_DEPTH];
  logic [DW-1:0]         rd_wptr_r, rd_rptr_r;
  logic [DW:0]           rd_cnt_r;
  logic                  rd_pop_s, rd_empty_s, rd_full_s, rd_room_s;
  logic [31:0]           rd_data_s;
  // Engine and RAM
  state_t                state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] ptr_r, ptr_nxt_s;
  logic [6:0]            rem_r, rem_nxt_s;
  logic                  ram_we_s, issue_s, in_flight_r;
  logic [31:0]           ram_r [2**ADDR_WIDTH];
  logic [31:0]           ram_q_r;
  logic                  unused_addr_s;

  assign unused_addr_s = ^{bus.cmd_addr[29:ADDR_WIDTH+2], bus.cmd_addr[1:0]};

  assign cmd_empty_s = (cmd_cnt_r == {(CW+1){1'b0}});
  assign cmd_full_s  = (cmd_cnt_r == CMD_DEPTH_C);
  assign cmd_push_s  = bus.cmd_en && !cmd_full_s;
  assign {head_instr_s, head_bl_s, head_ptr_s} = cmd_mem_r[cmd_rptr_r];

  assign wr_empty_s  = (wr_cnt_r == {(DW+1){1'b0}});
  assign wr_full_s   = (wr_cnt_r == DATA_DEPTH_C);
  assign wr_push_s   = bus.wr_en && !wr_full_s;
  assign {wr_head_mask_s, wr_head_data_s} = wr_mem_r[wr_rptr_r];

  assign rd_empty_s  = (rd_cnt_r == {(DW+1){1'b0}});
  assign rd_full_s   = (rd_cnt_r == DATA_DEPTH_C);
  assign rd_pop_s    = bus.rd_en && !rd_empty_s;
  // In-flight RAM read is counted so the FIFO can never overflow.
  assign rd_room_s   = ((rd_cnt_r + {{DW{1'b0}}, in_flight_r}) < DATA_DEPTH_C);

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wptr_r <= {CW{1'b0}};
      cmd_rptr_r <= {CW{1'b0}};
      cmd_cnt_r  <= {(CW+1){1'b0}};
    end else begin
      if (cmd_push_s) cmd_wptr_r <= cmd_wptr_r + 1'b1;
      if (cmd_pop_s)  cmd_rptr_r <= cmd_rptr_r + 1'b1;
      case ({cmd_push_s, cmd_pop_s})
        2'b10:   cmd_cnt_r <= cmd_cnt_r + 1'b1;
        2'b01:   cmd_cnt_r <= cmd_cnt_r - 1'b1;
        default: cmd_cnt_r <= cmd_cnt_r;
      endcase
    end
  end

  // Write FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_wptr_r <= {DW{1'b0}};
      wr_rptr_r <= {DW{1'b0}};
      wr_cnt_r  <= {(DW+1){1'b0}};
    end else begin
      if (wr_push_s) wr_wptr_r <= wr_wptr_r + 1'b1;
      if (wr_pop_s)  wr_rptr_r <= wr_rptr_r + 1'b1;
      case ({wr_push_s, wr_pop_s})
        2'b10:   wr_cnt_r <= wr_cnt_r + 1'b1;
        2'b01:   wr_cnt_r <= wr_cnt_r - 1'b1;
        default: wr_cnt_r <= wr_cnt_r;
      endcase
    end
  end

  // Read FIFO pointers and occupancy; pushes come from the in-flight RAM read
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wptr_r   <= {DW{1'b0}};
      rd_rptr_r   <= {DW{1'b0}};
      rd_cnt_r    <= {(DW+1){1'b0}};
      in_flight_r <= 1'b0;
    end else begin
      in_flight_r <= issue_s;
      if (in_flight_r) rd_wptr_r <= rd_wptr_r + 1'b1;
      if (rd_pop_s)    rd_rptr_r <= rd_rptr_r + 1'b1;
      case ({in_flight_r, rd_pop_s})
        2'b10:   rd_cnt_r <= rd_cnt_r + 1'b1;
        2'b01:   rd_cnt_r <= rd_cnt_r - 1'b1;
        default: rd_cnt_r <= rd_cnt_r;
      endcase
    end
  end

  // FIFO storage arrays (contents need no reset; occupancy guards them)
  always_ff @(posedge clk) begin
    if (cmd_push_s)  cmd_mem_r[cmd_wptr_r] <= {bus.cmd_instr, bus.cmd_bl, bus.cmd_addr[ADDR_WIDTH+1:2]};
    if (wr_push_s)   wr_mem_r[wr_wptr_r]   <= {bus.wr_mask, bus.wr_data};
    if (in_flight_r) rd_mem_r[rd_wptr_r]   <= ram_q_r;
  end

  // Backing RAM: byte-masked write port and synchronous read; survives reset
  always_ff @(posedge clk) begin
    if (ram_we_s && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (!wr_head_mask_s[i]) ram_r[ptr_r][8*i +: 8] <= wr_head_data_s[8*i +: 8];
      end
    end
    if (issue_s) ram_q_r <= ram_r[ptr_r];
  end

  // Engine state, word pointer and remaining-word count
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= {ADDR_WIDTH{1'b0}};
      rem_r   <= 7'd0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      rem_r   <= rem_nxt_s;
    end
  end

  // Engine next state: pop a command in IDLE, then move one word per cycle
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    rem_nxt_s   = rem_r;
    cmd_pop_s   = 1'b0;
    wr_pop_s    = 1'b0;
    ram_we_s    = 1'b0;
    issue_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!cmd_empty_s) begin
          cmd_pop_s = 1'b1;
          ptr_nxt_s = head_ptr_s;
          rem_nxt_s = {1'b0, head_bl_s} + 7'd1;
          case (head_instr_s)
            3'd0, 3'd2: state_nxt_s = WRITE;
            3'd1, 3'd3: state_nxt_s = READ;
            default:    state_nxt_s = IDLE;
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (!wr_empty_s) begin
          wr_pop_s    = 1'b1;
          ram_we_s    = 1'b1;
          ptr_nxt_s   = ptr_r + 1'b1;
          rem_nxt_s   = rem_r - 7'd1;
          state_nxt_s = (rem_r == 7'd1) ? IDLE : WRITE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      READ: begin
        if (rd_room_s) begin
          issue_s     = 1'b1;
          ptr_nxt_s   = ptr_r + 1'b1;
          rem_nxt_s   = rem_r - 7'd1;
          state_nxt_s = (rem_r == 7'd1) ? IDLE : READ;
        end else begin
          state_nxt_s = READ;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Read head presented as zero while the FIFO is empty
  always_comb begin
    rd_data_s = 32'd0;
    if (!rd_empty_s) begin
      rd_data_s = rd_mem_r[rd_rptr_r];
    end else begin
      rd_data_s = 32'd0;
    end
  end

  assign bus.cmd_full    = cmd_full_s;
  assign bus.cmd_empty   = cmd_empty_s;
  assign bus.wr_full     = wr_full_s;
  assign bus.wr_empty    = wr_empty_s;
  assign bus.wr_count    = 7'(wr_cnt_r);
  assign bus.wr_underrun = (state_r == WRITE) && wr_empty_s;
  assign bus.rd_data     = rd_data_s;
  assign bus.rd_empty    = rd_empty_s;
  assign bus.rd_full     = rd_full_s;
  assign bus.rd_count    = 7'(rd_cnt_r);
  assign bus.busy        = (state_r != IDLE) || !cmd_empty_s;
endmodule

// File: tb/tb_qm_mem_responder.sv
// tb_qm_mem_responder: directed self-checking bench for qm_mem_responder.
module tb_qm_mem_responder;
  logic clk = 1'b0;
  logic reset;
  int   checks_total  = 0;
  int   checks_passed = 0;

  qm_mem_responder_if bus ();

  qm_mem_responder #(
    .ADDR_WIDTH (10),
    .CMD_DEPTH  (4),
    .DATA_DEPTH (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
    bus.cmd_en = 1'b1; bus.cmd_instr = instr; bus.cmd_bl = bl; bus.cmd_addr = addr;
    @(negedge clk);
    bus.cmd_en = 1'b0;
  endtask

  task automatic push_wr(input logic [3:0] mask, input logic [31:0] data);
    bus.wr_en = 1'b1; bus.wr_mask = mask; bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pop_rd(input string tag, input logic [31:0] exp);
    int n = 0;
    while (bus.rd_empty && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " avail"}, {31'd0, bus.rd_empty}, 32'd0);
    check({tag, " data"}, bus.rd_data, exp);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
    tick(2);
  endtask

  task automatic wait_rd_count(input string tag, input logic [6:0] cnt);
    int n = 0;
    while (bus.rd_count != cnt && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {25'd0, bus.rd_count}, {25'd0, cnt});
  endtask

  initial begin
    bus.cmd_en = 1'b0; bus.cmd_instr = 3'd0; bus.cmd_bl = 6'd0; bus.cmd_addr = 30'd0;
    bus.wr_en = 1'b0; bus.wr_mask = 4'd0; bus.wr_data = 32'd0; bus.rd_en = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // Reset state
    check("rst cmd_full",    {31'd0, bus.cmd_full},    32'd0);
    check("rst cmd_empty",   {31'd0, bus.cmd_empty},   32'd1);
    check("rst wr_full",     {31'd0, bus.wr_full},     32'd0);
    check("rst wr_empty",    {31'd0, bus.wr_empty},    32'd1);
    check("rst wr_count",    {25'd0, bus.wr_count},    32'd0);
    check("rst wr_underrun", {31'd0, bus.wr_underrun}, 32'd0);
    check("rst rd_empty",    {31'd0, bus.rd_empty},    32'd1);
    check("rst rd_full",     {31'd0, bus.rd_full},     32'd0);
    check("rst rd_count",    {25'd0, bus.rd_count},    32'd0);
    check("rst rd_data",     bus.rd_data,              32'd0);
    check("rst busy",        {31'd0, bus.busy},        32'd0);

    // Four-word write then read-back at byte address 0x400
    push_wr(4'h0, 32'h1111_1111);
    push_wr(4'h0, 32'h2222_2222);
    push_wr(4'h0, 32'h3333_3333);
    push_wr(4'h0, 32'h4444_4444);
    check("wr_count 4", {25'd0, bus.wr_count}, 32'd4);
    push_cmd(3'd0, 6'd3, 30'h400);
    check("busy after cmd", {31'd0, bus.busy}, 32'd1);
    push_cmd(3'd1, 6'd3, 30'h400);
    wait_rd_count("burst rd_count", 7'd4);
    pop_rd("burst w0", 32'h1111_1111);
    pop_rd("burst w1", 32'h2222_2222);
    pop_rd("burst w2", 32'h3333_3333);
    pop_rd("burst w3", 32'h4444_4444);
    wait_idle("burst");

    // Single-word read latency from an idle engine
    push_cmd(3'd3, 6'd0, 30'h400);
    check("lat edge0", {31'd0, bus.rd_empty}, 32'd1);
    tick(1);
    check("lat edge1", {31'd0, bus.rd_empty}, 32'd1);
    tick(1);
    check("lat edge2", {31'd0, bus.rd_empty}, 32'd1);
    tick(1);
    check("lat edge3", {31'd0, bus.rd_empty}, 32'd0);
    check("lat data",  bus.rd_data, 32'h1111_1111);
    pop_rd("lat pop", 32'h1111_1111);
    wait_idle("lat");

    // Byte mask: bytes 0 and 2 keep the zero background
    push_wr(4'h0, 32'h0000_0000);
    push_cmd(3'd0, 6'd0, 30'h800);
    push_wr(4'b0101, 32'hAABB_CCDD);
    push_cmd(3'd2, 6'd0, 30'h800);
    push_cmd(3'd1, 6'd0, 30'h800);
    pop_rd("mask", 32'hAA00_CC00);
    wait_idle("mask");

    // Fill words 0..63 with a known pattern, command ahead of data
    push_cmd(3'd0, 6'd63, 30'h0);
    for (int i = 0; i < 64; i++) push_wr(4'h0, 32'h1000_0000 + i);
    wait_idle("fill");

    // Read backpressure: full read FIFO stalls a following read
    push_cmd(3'd1, 6'd63, 30'h0);
    wait_rd_count("bp rd_count", 7'd64);
    check("bp rd_full", {31'd0, bus.rd_full}, 32'd1);
    push_cmd(3'd1, 6'd0, 30'h400);
    tick(5);
    check("bp stall busy", {31'd0, bus.busy}, 32'd1);
    check("bp stall count", {25'd0, bus.rd_count}, 32'd64);
    pop_rd("bp first", 32'h1000_0000);
    wait_rd_count("bp refill", 7'd64);
    for (int i = 1; i < 64; i++) pop_rd($sformatf("bp w%0d", i), 32'h1000_0000 + i);
    pop_rd("bp extra", 32'h1111_1111);
    wait_idle("bp");

    // Write underrun: second word of a 2-word burst arrives late
    push_wr(4'h0, 32'hCAFE_0001);
    push_cmd(3'd0, 6'd1, 30'hC00);
    begin
      int n = 0;
      while (!bus.wr_underrun && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("underrun set", {31'd0, bus.wr_underrun}, 32'd1);
    push_wr(4'h0, 32'hCAFE_0002);
    check("underrun clear", {31'd0, bus.wr_underrun}, 32'd0);
    wait_idle("underrun");
    push_cmd(3'd1, 6'd1, 30'hC00);
    pop_rd("underrun w0", 32'hCAFE_0001);
    pop_rd("underrun w1", 32'hCAFE_0002);
    wait_idle("underrun rd");

    // Reset in the middle of a read burst
    push_cmd(3'd1, 6'd63, 30'h0);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid rst rd_empty",  {31'd0, bus.rd_empty},  32'd1);
    check("mid rst rd_count",  {25'd0, bus.rd_count},  32'd0);
    check("mid rst busy",      {31'd0, bus.busy},      32'd0);
    check("mid rst cmd_empty", {31'd0, bus.cmd_empty}, 32'd1);
    check("mid rst rd_data",   bus.rd_data,            32'd0);
    tick(4);
    check("mid rst abandoned", {31'd0, bus.rd_empty},  32'd1);

    // Command FIFO full while the engine is blocked; fifth push dropped
    push_cmd(3'd1, 6'd63, 30'h0);
    push_cmd(3'd1, 6'd0, 30'h400);
    wait_rd_count("blk rd_count", 7'd64);
    begin
      int n = 0;
      while (!bus.cmd_empty && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("blk cmd_empty", {31'd0, bus.cmd_empty}, 32'd1);
    for (int i = 1; i <= 4; i++) push_cmd(3'd1, 6'd0, 30'(4 * i));
    check("blk cmd_full", {31'd0, bus.cmd_full}, 32'd1);
    push_cmd(3'd1, 6'd0, 30'd20);
    check("blk cmd_full hold", {31'd0, bus.cmd_full}, 32'd1);
    for (int i = 0; i < 64; i++) pop_rd($sformatf("blk w%0d", i), 32'h1000_0000 + i);
    pop_rd("blk extra", 32'h1111_1111);
    for (int i = 1; i <= 4; i++) pop_rd($sformatf("blk cmd%0d", i), 32'h1000_0000 + i);
    wait_idle("blk");
    tick(3);
    check("blk fifth dropped", {31'd0, bus.rd_empty}, 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
